cache_mem_arbiter: RTL
======================

// Module: cache_mem_arbiter
// PURPOSE
//  Memory-side responder for the icache and dcache miss/write-back traffic.
//  Arbitrates single-word requests from both caches onto one RAM port.
//  Returns wait/load to the granted cache. Dcache has priority; icache gets an anti-starvation override.
//  Sits between the cache pair and the RAM model/controller.
// PARAMETERS
//  ADDR_W        32  byte address width
//  WORD_W        32  data word width
//  STARVE_LIMIT  4   consecutive dcache words tolerated while iREN pending (>=1)
// PORTS
//  CLK       in   1       clock, rising edge
//  RST       in   1       asynchronous reset, active-high
//  iREN      in   1       icache word read request (held until iwait=0)
//  iaddr     in   ADDR_W  icache word address
//  iwait     out  1       1 = icache request not yet complete
//  iload     out  WORD_W  icache read data, valid when iREN & !iwait
//  dREN      in   1       dcache word read request
//  dWEN      in   1       dcache word write request (write-back)
//  daddr     in   ADDR_W  dcache word address
//  dstore    in   WORD_W  dcache write data
//  dwait     out  1       1 = dcache request not yet complete
//  dload     out  WORD_W  dcache read data, valid when dREN & !dwait
//  ramREN    out  1       RAM read enable
//  ramWEN    out  1       RAM write enable
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  WORD_W  RAM write data
//  ramload   in   WORD_W  RAM read data
//  ramstate  in   2       0 FREE, 1 BUSY, 2 ACCESS (word done), 3 ERROR
//  mem_err   out  1       sticky: RAM returned ERROR since reset
// BEHAVIOUR
//  FSM states: ARB, DGRANT, IGRANT. Reset -> ARB, starve_cnt=0, mem_err=0.
//  ARB: no RAM enables driven. Next state:
//   - iREN & starve_cnt==STARVE_LIMIT -> IGRANT
//   - else dREN|dWEN -> DGRANT
//   - else iREN -> IGRANT
//   - else stay.
//  DGRANT: ramaddr=daddr, ramstore=dstore. dWEN -> ramWEN=1, else ramREN=1.
//   dWEN & dREN together is illegal; write wins.
//  IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0.
//  Completion: granted state & ramstate==ACCESS.
//   - Granted wait=0 that same cycle (combinational).
//   - load = ramload (combinational passthrough).
//   - Next state ARB: one bubble cycle per word, so the requester can update its address.
//  Minimum word latency: request seen in ARB, granted next cycle.
//   ACCESS in the grant cycle -> wait low 2nd cycle after request.
//  Waits: iwait = iREN & !(IGRANT & ACCESS); dwait = (dREN|dWEN) & !(DGRANT & ACCESS).
//   Both are 0 when no request. In reset, waits follow requests; RAM enables and mem_err are 0.
//  Ungranted outputs: iload/dload = ramload always; qualified by wait only.
//   ramaddr/ramstore = 0 in ARB.
//  Request withdrawn while granted (enable low): abort, RAM enables drop same cycle, -> ARB.
//   No completion and no counter change.
//  ERROR in a grant state:
//   - mem_err <= 1 (sticky until RST); -> ARB.
//   - Requester wait stays 1, so it retries via normal arbitration.
//   - starve_cnt unchanged.
//  starve_cnt (saturating at STARVE_LIMIT):
//   - +1 on each dcache completion while iREN=1.
//   - Cleared on icache completion or any cycle with iREN=0.
//  Dcache 2-word bursts (load/write-back) are two independent word transactions.
//   The icache may be interleaved between them only via the starvation override.
//  Mid-operation RST: immediate return to ARB, enables drop asynchronously; in-flight word is lost.
// TESTING
//  1. iREN=1 iaddr=0x40, ramstate ACCESS on 1st IGRANT cycle, ramload=0xDEADBEEF
//     -> ramREN=1 ramaddr=0x40 one cycle; iwait low in that cycle with iload=0xDEADBEEF; then ARB.
//  2. iREN and dWEN raised same cycle, daddr=0x80 dstore=0x1234
//     -> DGRANT first (ramWEN=1 ramstore=0x1234); IGRANT after the ARB bubble.
//  3. STARVE_LIMIT=4, dREN held for 6 words, iREN held
//     -> 4 dcache completions, then IGRANT; then dcache resumes.
//  4. dREN granted, ramstate BUSY 3 cycles then ERROR
//     -> dwait stays 1, mem_err=1 stays set; retry completes on later ACCESS.
//  5. dREN granted then dropped before ACCESS
//     -> ramREN=0 same cycle, state ARB, dwait=0, starve_cnt unchanged.
//  6. RST asserted during IGRANT with ramREN=1
//     -> ramREN=0 without a clock edge; mem_err=0; state ARB after release.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache single-word requests onto one RAM port (dcache priority, icache anti-starvation).
// Latency: request seen in ARB, granted next cycle; wait drops combinationally in the RAM ACCESS cycle.
// Backpressure: requesters hold enables while wait=1; RAM BUSY stretches the grant, ERROR forces a retry.
module cache_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  // icache side
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  // dcache side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  // RAM port
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  // status
  output logic              mem_err
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic              d_req;
  logic              i_done;
  logic              d_done;
  logic              err_hit;
  logic              ren_c;
  logic              wen_c;
  logic [ADDR_W-1:0] addr_c;
  logic [WORD_W-1:0] store_c;
  logic              ram_busy_unused;

  assign d_req = dREN | dWEN;

  // FREE and BUSY both mean "keep the grant"; named here only so the decode reads clearly
  assign ram_busy_unused = (ramstate == RS_FREE) | (ramstate == RS_BUSY);

  // State register: reset drops straight back to ARB, abandoning any in-flight word
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ARB;
    else     state <= state_nxt;
  end

  // Next-state and RAM port drive; a withdrawn request aborts without completing
  always_comb begin
    state_nxt = state;
    ren_c     = 1'b0;
    wen_c     = 1'b0;
    addr_c    = '0;
    store_c   = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    err_hit   = 1'b0;
    case (state)
      ARB: begin
        if (iREN && (starve_cnt == LIMIT)) state_nxt = IGRANT;
        else if (d_req)                    state_nxt = DGRANT;
        else if (iREN)                     state_nxt = IGRANT;
      end
      DGRANT: begin
        addr_c  = daddr;
        store_c = dstore;
        if (!d_req) begin
          state_nxt = ARB;
        end else begin
          // a simultaneous read+write is illegal; the write-back wins
          wen_c = dWEN;
          ren_c = ~dWEN;
          if (ramstate == RS_ACCESS) begin
            d_done    = 1'b1;
            state_nxt = ARB;
          end else if (ramstate == RS_ERROR) begin
            err_hit   = 1'b1;
            state_nxt = ARB;
          end
        end
      end
      IGRANT: begin
        addr_c = iaddr;
        if (!iREN) begin
          state_nxt = ARB;
        end else begin
          ren_c = 1'b1;
          if (ramstate == RS_ACCESS) begin
            i_done    = 1'b1;
            state_nxt = ARB;
          end else if (ramstate == RS_ERROR) begin
            err_hit   = 1'b1;
            state_nxt = ARB;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Enables are also gated by reset so they fall without waiting on the state flop
  assign ramREN   = ren_c & ~RST;
  assign ramWEN   = wen_c & ~RST;
  assign ramaddr  = addr_c;
  assign ramstore = store_c;

  assign iwait = iREN  & ~i_done;
  assign dwait = d_req & ~d_done;
  assign iload = ramload;
  assign dload = ramload;

  // Count back-to-back dcache words the icache has had to sit through
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (!iREN || i_done) begin
      starve_cnt <= '0;
    end else if (d_done && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Sticky error flag: any ERROR on an active grant since reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          mem_err <= 1'b0;
    else if (err_hit) mem_err <= 1'b1;
  end

endmodule
